// File: rtl/usr_burst_shifter_pkg.sv
// usr_pkg: shared definitions for the burst shifter slice.
// Holds the operation encoding used on the 3-bit mode select and the
// two-state burst FSM encoding. Codes 000-011 match the legacy 2-bit select.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROTR = 3'b100;
  localparam logic [2:0] MODE_ROTL = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage : usr_pkg

// File: rtl/usr_burst_shifter_if.sv
// usr_burst_shifter_if: control/data bundle of the burst shifter.
// master : drives en, mode, s_r_in, s_l_in, p_in, start, burst_len;
//          observes q, s_r_out, s_l_out, busy, done.
// slave  : the shifter itself (mirror directions).
interface usr_burst_shifter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) ();

  logic             en;
  logic [2:0]       mode;
  logic             s_r_in;
  logic             s_l_in;
  logic [WIDTH-1:0] p_in;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic [WIDTH-1:0] q;
  logic             s_r_out;
  logic             s_l_out;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, s_r_in, s_l_in, p_in, start, burst_len,
    input  q, s_r_out, s_l_out, busy, done
  );

  modport slave (
    input  en, mode, s_r_in, s_l_in, p_in, start, burst_len,
    output q, s_r_out, s_l_out, busy, done
  );

endinterface : usr_burst_shifter_if

// File: rtl/usr_burst_shifter_op_mux.sv
// usr_op_mux: combinational next-value generator for the shift register.
// Ports:
//   i_q      current register value
//   i_mode   operation select (usr_pkg MODE_*)
//   i_s_r_in serial bit entering the MSB on SHR
//   i_s_l_in serial bit entering the LSB on SHL
//   i_p_in   parallel load value
//   o_q_next value the register takes if this operation is applied
module usr_op_mux
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [2:0]       i_mode,
  input  logic             i_s_r_in,
  input  logic             i_s_l_in,
  input  logic [WIDTH-1:0] i_p_in,
  output logic [WIDTH-1:0] o_q_next
);

  // Select the next register value for the requested operation.
  always_comb begin
    o_q_next = i_q;
    case (i_mode)
      MODE_HOLD: o_q_next = i_q;
      MODE_SHR:  o_q_next = {i_s_r_in, i_q[WIDTH-1:1]};
      MODE_SHL:  o_q_next = {i_q[WIDTH-2:0], i_s_l_in};
      MODE_LOAD: o_q_next = i_p_in;
      MODE_ROTR: o_q_next = {i_q[0], i_q[WIDTH-1:1]};
      MODE_ROTL: o_q_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
      MODE_ASR:  o_q_next = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
      // 3'b111 is reserved and holds the register.
      default:   o_q_next = i_q;
    endcase
  end

endmodule : usr_op_mux

// File: rtl/usr_burst_shifter.sv
// usr_burst_shifter: WIDTH-bit universal shift register with counted bursts.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  slave side of usr_burst_shifter_if (en, mode, serial/parallel
//        inputs, start/burst_len request; q, serial outs, busy, done)
// In IDLE every enabled edge applies the live mode; a start with a non-zero
// length latches the mode and runs it burst_len times, one per enabled edge.
module usr_burst_shifter
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  usr_burst_shifter_if.slave   bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       r_mode;
  logic [2:0]       w_mode_next;
  logic             r_done;
  logic             w_done_next;
  logic [2:0]       w_op_mode;
  logic [WIDTH-1:0] w_op_q;

  // During a burst the latched mode drives the operation, otherwise the live one.
  assign w_op_mode = (r_state == ST_BURST) ? r_mode : bus.mode;

  usr_op_mux #(.WIDTH(WIDTH)) u_op_mux (
    .i_q      (r_q),
    .i_mode   (w_op_mode),
    .i_s_r_in (bus.s_r_in),
    .i_s_l_in (bus.s_l_in),
    .i_p_in   (bus.p_in),
    .o_q_next (w_op_q)
  );

  // Next-state, counter, latched mode, register and done-pulse decisions.
  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_cnt_next   = r_cnt;
    w_mode_next  = r_mode;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.en) begin
          if (bus.start) begin
            if (bus.burst_len != {CNT_W{1'b0}}) begin
              // Acceptance edge: q untouched, operations start next edge.
              w_mode_next  = bus.mode;
              w_cnt_next   = bus.burst_len;
              w_state_next = ST_BURST;
            end else begin
              // Zero-length burst completes immediately.
              w_done_next = 1'b1;
            end
          end else begin
            w_q_next = w_op_q;
          end
        end else begin
          w_q_next = r_q;
        end
      end
      ST_BURST: begin
        if (bus.en) begin
          w_q_next   = w_op_q;
          w_cnt_next = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = ST_BURST;
          end
        end else begin
          // Stall: everything frozen, busy stays high.
          w_state_next = ST_BURST;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, data, counter, latched mode and done registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_q     <= {WIDTH{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_mode  <= MODE_HOLD;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_cnt   <= w_cnt_next;
      r_mode  <= w_mode_next;
      r_done  <= w_done_next;
    end
  end

  assign bus.q       = r_q;
  assign bus.s_r_out = r_q[0];
  assign bus.s_l_out = r_q[WIDTH-1];
  assign bus.busy    = (r_state == ST_BURST);
  assign bus.done    = r_done;

endmodule : usr_burst_shifter

// File: tb/tb_usr_burst_shifter.sv
// Self-checking bench for usr_burst_shifter (WIDTH=8): directed vector table,
// a reset-mid-burst sequence, then random stimulus against a reference model.
module tb_usr_burst_shifter;

  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  usr_burst_shifter_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  usr_burst_shifter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          en;
    logic [2:0]    mode;
    logic          sr;
    logic          sl;
    logic [W-1:0]  p;
    logic          start;
    logic [CW-1:0] bl;
    logic [W-1:0]  exp_q;
    logic          exp_busy;
    logic          exp_done;
  } vec_t;

  vec_t vq[$];

  // Reference model: value after one operation, by plain arithmetic.
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] q, input logic [2:0] m,
                                          input logic sr, input logic sl, input logic [W-1:0] p);
    int v;
    v = int'(q);
    case (m)
      3'd1:    v = (v / 2) + (sr ? 128 : 0);
      3'd2:    v = ((v * 2) % 256) + (sl ? 1 : 0);
      3'd3:    v = int'(p);
      3'd4:    v = (v / 2) + ((v % 2) * 128);
      3'd5:    v = ((v * 2) % 256) + (v / 128);
      3'd6:    v = (v / 2) + ((v >= 128) ? 128 : 0);
      default: v = v;
    endcase
    return v[W-1:0];
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [2:0] mode, input logic sr, input logic sl,
                     input logic [W-1:0] p, input logic start, input logic [CW-1:0] bl,
                     input logic [W-1:0] eq, input logic eb, input logic ed);
    vec_t v;
    v.en = en; v.mode = mode; v.sr = sr; v.sl = sl; v.p = p; v.start = start; v.bl = bl;
    v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
    vq.push_back(v);
  endtask

  task automatic drive(input logic en, input logic [2:0] mode, input logic sr, input logic sl,
                       input logic [W-1:0] p, input logic start, input logic [CW-1:0] bl);
    bus.en = en; bus.mode = mode; bus.s_r_in = sr; bus.s_l_in = sl;
    bus.p_in = p; bus.start = start; bus.burst_len = bl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [W-1:0] eq,
                         input logic eb, input logic ed);
    chk({tag, "_q"}, idx, 32'(bus.q), 32'(eq));
    chk({tag, "_busy"}, idx, 32'(bus.busy), 32'(eb));
    chk({tag, "_done"}, idx, 32'(bus.done), 32'(ed));
    chk({tag, "_srout"}, idx, 32'(bus.s_r_out), 32'(eq[0]));
    chk({tag, "_slout"}, idx, 32'(bus.s_l_out), 32'(eq[W-1]));
  endtask

  logic [W-1:0]  m_q;
  int            m_left;
  logic [2:0]    m_mode;
  logic          m_done;

  initial begin
    drive(1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0);

    // ---------------- reset state ----------------
    #12;
    chk_all("reset", 0, 8'h00, 1'b0, 1'b0);
    #1 rst = 1'b1;
    tick();

    // ---------------- directed table ----------------
    //  en  mode  sr sl p      st bl     q      busy done
    add(1, 3'd3, 0, 0, 8'hA5, 0, 4'd0, 8'hA5, 0, 0);  // LOAD
    add(1, 3'd1, 1, 0, 8'h00, 0, 4'd0, 8'hD2, 0, 0);  // SHR in=1
    add(1, 3'd3, 0, 0, 8'hA5, 0, 4'd0, 8'hA5, 0, 0);
    add(1, 3'd2, 0, 0, 8'h00, 0, 4'd0, 8'h4A, 0, 0);  // SHL in=0
    add(1, 3'd3, 0, 0, 8'h81, 0, 4'd0, 8'h81, 0, 0);
    add(1, 3'd4, 0, 0, 8'h00, 1, 4'd3, 8'h81, 1, 0);  // ROTR x3 accepted
    add(1, 3'd3, 0, 0, 8'hFF, 1, 4'd5, 8'hC0, 1, 0);  // start/mode ignored
    add(1, 3'd3, 0, 0, 8'hFF, 0, 4'd0, 8'h60, 1, 0);
    add(1, 3'd3, 0, 0, 8'hFF, 0, 4'd0, 8'h30, 0, 1);
    add(1, 3'd0, 0, 0, 8'h00, 0, 4'd0, 8'h30, 0, 0);
    add(1, 3'd3, 0, 0, 8'h90, 0, 4'd0, 8'h90, 0, 0);
    add(1, 3'd6, 0, 0, 8'h00, 1, 4'd2, 8'h90, 1, 0);  // ASR x2 accepted
    add(1, 3'd2, 0, 1, 8'h00, 0, 4'd0, 8'hC8, 1, 0);
    add(0, 3'd3, 0, 0, 8'h11, 0, 4'd0, 8'hC8, 1, 0);  // stall
    add(0, 3'd1, 1, 1, 8'h11, 1, 4'd1, 8'hC8, 1, 0);  // stall
    add(1, 3'd3, 0, 0, 8'h11, 0, 4'd0, 8'hE4, 0, 1);
    add(1, 3'd3, 0, 0, 8'h5A, 0, 4'd0, 8'h5A, 0, 0);
    add(1, 3'd7, 1, 1, 8'hFF, 0, 4'd0, 8'h5A, 0, 0);  // reserved
    add(1, 3'd0, 1, 1, 8'hFF, 0, 4'd0, 8'h5A, 0, 0);
    add(1, 3'd7, 0, 0, 8'h00, 0, 4'd0, 8'h5A, 0, 0);
    add(1, 3'd0, 0, 0, 8'h00, 0, 4'd0, 8'h5A, 0, 0);
    add(1, 3'd1, 1, 0, 8'h00, 1, 4'd0, 8'h5A, 0, 1);  // zero-length burst
    add(1, 3'd5, 0, 0, 8'h00, 1, 4'd2, 8'h5A, 1, 0);  // start in done cycle
    add(1, 3'd0, 0, 0, 8'h00, 0, 4'd0, 8'hB4, 1, 0);
    add(1, 3'd0, 0, 0, 8'h00, 0, 4'd0, 8'h69, 0, 1);
    add(1, 3'd1, 1, 0, 8'h00, 1, 4'd1, 8'h69, 1, 0);  // back-to-back
    add(1, 3'd0, 1, 0, 8'h00, 0, 4'd0, 8'hB4, 0, 1);  // live s_r_in in burst
    add(0, 3'd3, 0, 0, 8'h00, 1, 4'd3, 8'hB4, 0, 0);  // en=0 ignores start
    add(1, 3'd0, 0, 0, 8'h00, 0, 4'd0, 8'hB4, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].en, vq[i].mode, vq[i].sr, vq[i].sl, vq[i].p, vq[i].start, vq[i].bl);
      tick();
      chk_all("vec", i, vq[i].exp_q, vq[i].exp_busy, vq[i].exp_done);
    end

    // ---------------- async reset mid-burst ----------------
    drive(1, 3'd3, 0, 0, 8'h3C, 0, 4'd0); tick();
    drive(1, 3'd4, 0, 0, 8'h00, 1, 4'd3); tick();
    drive(1, 3'd0, 0, 0, 8'h00, 0, 4'd0); tick();   // one op done, two left
    chk_all("midburst", 0, 8'h1E, 1'b1, 1'b0);
    #3 rst = 1'b0;
    #1 chk_all("async_rst", 0, 8'h00, 1'b0, 1'b0);
    #3 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all("post_rst", k, 8'h00, 1'b0, 1'b0);
    end

    // ---------------- random vs reference model ----------------
    m_q = 8'h00; m_left = 0; m_mode = 3'd0; m_done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic          r_en, r_sr, r_sl, r_st, nd;
      logic [2:0]    r_md;
      logic [W-1:0]  r_p;
      logic [CW-1:0] r_bl;
      r_en = ($urandom_range(0, 4) != 0);
      r_md = 3'($urandom_range(0, 7));
      r_sr = 1'($urandom_range(0, 1));
      r_sl = 1'($urandom_range(0, 1));
      r_p  = 8'($urandom_range(0, 255));
      r_st = ($urandom_range(0, 3) == 0);
      r_bl = 4'($urandom_range(0, 8));
      drive(r_en, r_md, r_sr, r_sl, r_p, r_st, r_bl);
      nd = 1'b0;
      if (r_en) begin
        if (m_left > 0) begin
          m_q = ref_op(m_q, m_mode, r_sr, r_sl, r_p);
          m_left--;
          if (m_left == 0) nd = 1'b1;
        end else if (r_st) begin
          if (r_bl == 4'd0) nd = 1'b1;
          else begin
            m_mode = r_md;
            m_left = int'(r_bl);
          end
        end else begin
          m_q = ref_op(m_q, r_md, r_sr, r_sl, r_p);
        end
      end
      m_done = nd;
      tick();
      chk_all("rnd", n, m_q, (m_left > 0), m_done);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_usr_burst_shifter

// File: doc/usr_burst_shifter.md
Name: usr_burst_shifter

Overview:
- Parametrised WIDTH-bit universal shift register. Successor to the single-bit mux+flop cell.
- Adds rotate, arithmetic shift, serial outputs and a counted burst mode with busy/done handshake.
- Sits between the serial/parallel data paths: either stepped one operation per enabled cycle, or told to run N identical shifts autonomously.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), width of burst_len. Allows bursts of 0..WIDTH.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; 0 freezes all state, including the burst counter.
- mode  input  3  operation select (encoding below).
- s_r_in  input  1  serial input for shift right (enters MSB).
- s_l_in  input  1  serial input for shift left (enters LSB).
- p_in  input  WIDTH  parallel load data.
- start  input  1  burst request, sampled in IDLE only.
- burst_len  input  CNT_W  number of operations to run in the burst.
- q  output  WIDTH  register contents.
- s_r_out  output  1  q[0], the bit shifted out on a right shift.
- s_l_out  output  1  q[WIDTH-1], the bit shifted out on a left shift.
- busy  output  1  high while in BURST.
- done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (rst=0, async): q=0, state=IDLE, cnt=0, latched mode=000, busy=0, done=0. Applies at any time, including mid-burst; the burst is aborted and done is not pulsed.
- Mode encoding:
  - 000 hold.
  - 001 SHR: q<={s_r_in,q[W-1:1]}.
  - 010 SHL: q<={q[W-2:0],s_l_in}.
  - 011 LOAD: q<=p_in.
  - 100 ROTR: q<={q[0],q[W-1:1]}.
  - 101 ROTL: q<={q[W-2:0],q[W-1]}.
  - 110 ASR: q<={q[W-1],q[W-1:1]}.
  - 111 reserved, behaves as hold.
- Codes 000-011 are bit-compatible with the legacy 2-bit select.
- s_r_out and s_l_out are combinational from q (no extra flop).
- Serial inputs are sampled live every operating edge, including during a burst.
- State machine has two states, IDLE and BURST.
- IDLE, en=1, start=0: apply mode on every edge (single-step).
- IDLE, en=1, start=1, burst_len>0:
  - Latch mode and set cnt<=burst_len.
  - q is unchanged on this edge.
  - Go to BURST.
- IDLE, en=1, start=1, burst_len=0: q unchanged, stay IDLE, done<=1 for one cycle.
- BURST, en=1:
  - Apply the latched mode and decrement cnt.
  - On the edge where cnt==1: go to IDLE and set done<=1.
- BURST, en=0: nothing changes (stall); busy stays 1.
- BURST: mode, start, p_in and burst_len inputs are ignored. A burst of LOAD just reloads p_in N times (legal).
- Latency: start accepted at edge k; operations on edges k+1..k+N (absent stalls); busy high in cycles k..k+N-1; done high for the single cycle after edge k+N, with state already IDLE.
- done defaults to 0 every cycle it is not explicitly set.
- start in the done cycle is accepted normally (back-to-back bursts).
- en=0 in IDLE: no action, start is not accepted, done stays 0 on that edge.

Decomposition:
- Package usr_pkg holds:
  - mode localparams: MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROTR, MODE_ROTL, MODE_ASR.
  - the state encoding: ST_IDLE, ST_BURST.
- One sub-module, usr_op_mux: purely combinational next-value generator (q, mode, s_r_in, s_l_in, p_in -> q_next). It generalises the per-bit 4:1 mux to WIDTH bits and 7 operations.
- The top holds the q register, counter, FSM and done flop.

Test Plan (WIDTH=8):
- Reset: drive rst=0 mid-burst (cnt=2) -> q=8'h00, busy=0, done=0 immediately (async); no done pulse after release.
- Single-step: LOAD p_in=8'hA5, then SHR with s_r_in=1 -> q=8'hD2, s_r_out=0. Reload 8'hA5, SHL with s_l_in=0 -> q=8'h4A, s_l_out=0.
- Rotate burst: q=8'h81, start with mode=ROTR, burst_len=3 -> q steps C0, 60, 30 on three successive edges. busy high for 3 cycles; done is high for exactly 1 cycle with q=8'h30.
- ASR burst with stall:
  - q=8'h90, ASR, burst_len=2; en=0 for 2 cycles between the two operations.
  - Required: q goes C8 then E4; done is delayed by exactly 2 cycles; mode changes during the burst have no effect.
- Zero-length and back-to-back:
  - start with burst_len=0 -> done pulse next cycle, q unchanged, busy never high.
  - start reasserted in a done cycle -> new burst accepted.
  - start during BURST -> ignored.
- Reserved/hold: mode=111 and mode=000 for 4 cycles with q=8'h5A -> q stays 8'h5A and done stays 0.
